// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes 'W'/'R' command frames from the receive
// byte stream, runs one picorv32-native bus transaction per frame and
// returns 'K', the read word (LSB first) or 'E' on the transmit side.
module uart_bus_master #(
   parameter int BUS_TIMEOUT   = 1024,
   parameter int FRAME_TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_drop,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   // +2 keeps the width at least 1 bit even when the timeout is disabled
   localparam int BTW = $clog2(BUS_TIMEOUT + 2);
   localparam int FTW = $clog2(FRAME_TIMEOUT + 2);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

   state_t          state_q;
   logic            is_wr_q;
   logic [1:0]      byte_cnt_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [31:0]     resp_q;      // remaining response bytes, next one in [7:0]
   logic [2:0]      resp_n_q;    // bytes still to be accepted, including tx_data_q
   logic [BTW-1:0]  bus_cnt_q;
   logic [FTW-1:0]  idle_cnt_q;
   logic            mem_valid_q;
   logic [3:0]      mem_wstrb_q;
   logic            tx_valid_q;
   logic [7:0]      tx_data_q;
   logic            rx_drop_q;

   logic bus_to;
   logic frame_to;

   // Expiry fires on the last allowed cycle so the phase lasts exactly TIMEOUT cycles
   assign bus_to   = (BUS_TIMEOUT != 0)   && (bus_cnt_q  == BTW'(BUS_TIMEOUT - 1));
   assign frame_to = (FRAME_TIMEOUT != 0) && (idle_cnt_q == FTW'(FRAME_TIMEOUT - 1));

   assign mem_valid = mem_valid_q;
   assign mem_instr = 1'b0;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign rx_drop   = rx_drop_q;
   assign busy      = (state_q != IDLE);

   // Command decode, bus phase and response sequencing
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         is_wr_q     <= 1'b0;
         byte_cnt_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         resp_q      <= '0;
         resp_n_q    <= '0;
         bus_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         mem_valid_q <= 1'b0;
         mem_wstrb_q <= 4'h0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         rx_drop_q   <= 1'b0;
      end else begin
         rx_drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx_valid && (rx_data == 8'h57 || rx_data == 8'h52)) begin
                  state_q    <= ADDR;
                  is_wr_q    <= (rx_data == 8'h57);
                  byte_cnt_q <= '0;
                  idle_cnt_q <= '0;
               end
            end
            ADDR, DATA: begin
               if (rx_valid) begin
                  idle_cnt_q <= '0;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (state_q == ADDR) addr_q[{byte_cnt_q, 3'b000} +: 8]  <= rx_data;
                  else                 wdata_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
                  if (byte_cnt_q == 2'd3) begin
                     if (state_q == ADDR && is_wr_q) begin
                        state_q <= DATA;
                     end else begin
                        state_q     <= BUS;
                        mem_valid_q <= 1'b1;
                        mem_wstrb_q <= is_wr_q ? 4'hF : 4'h0;
                        bus_cnt_q   <= '0;
                     end
                  end
               end else if (frame_to) begin
                  state_q <= IDLE;
               end else if (idle_cnt_q != '1) begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            BUS: begin
               rx_drop_q <= rx_valid;
               if (mem_ready) begin
                  mem_valid_q <= 1'b0;
                  mem_wstrb_q <= 4'h0;
                  tx_valid_q  <= 1'b1;
                  state_q     <= RESP;
                  if (is_wr_q) begin
                     tx_data_q <= 8'h4B;
                     resp_n_q  <= 3'd1;
                  end else begin
                     tx_data_q <= mem_rdata[7:0];
                     resp_q    <= {8'h00, mem_rdata[31:8]};
                     resp_n_q  <= 3'd4;
                  end
               end else if (bus_to) begin
                  mem_valid_q <= 1'b0;
                  mem_wstrb_q <= 4'h0;
                  tx_valid_q  <= 1'b1;
                  tx_data_q   <= 8'h45;
                  resp_n_q    <= 3'd1;
                  state_q     <= RESP;
               end else if (bus_cnt_q != '1) begin
                  bus_cnt_q <= bus_cnt_q + 1'b1;
               end
            end
            RESP: begin
               rx_drop_q <= rx_valid;
               if (tx_valid_q && tx_ready) begin
                  if (resp_n_q == 3'd1) begin
                     tx_valid_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     tx_data_q <= resp_q[7:0];
                     resp_q    <= {8'h00, resp_q[31:8]};
                     resp_n_q  <= resp_n_q - 3'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: frames driven on rx, a simple RAM responder on
// the bus, expected tx bytes queued per scenario and compared on completion.
module tb_uart_bus_master;
   localparam int BT = 16;
   localparam int FT = 40;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_drop;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        busy;

   uart_bus_master #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
      .clk(clk), .reset_n(reset_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_drop(rx_drop),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Responder: acks once mem_valid has been high for ack_lat prior cycles
   bit          resp_en = 1'b0;
   int          ack_lat = 0;
   logic [31:0] rdata_val = 32'h0;
   int          vcyc = 0;
   bit          rand_rdy = 1'b0;
   always @(posedge clk) vcyc <= mem_valid ? vcyc + 1 : 0;
   assign mem_ready = resp_en && mem_valid && (vcyc >= ack_lat);
   assign mem_rdata = rdata_val;

   always @(posedge clk) begin
      #1;
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          cyc;
      bit          u;
   } bus_rec_t;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   bus_rec_t   bus_q[$];
   int drops = 0;
   int hold_err = 0;

   logic pv = 1'b0, pr = 1'b0, pmv = 1'b0;
   logic [7:0] pd = 8'h0;
   int cur_cyc = 0;
   bus_rec_t cur;

   // Observe tx handshakes, tx hold rule, rx_drop pulses and bus phases
   always @(negedge clk) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (pv && !pr && (!tx_valid || tx_data != pd)) hold_err++;
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      if (rx_drop) drops++;
      if (mem_valid) begin
         if (!pmv) begin
            cur_cyc = 0;
            cur.u = 1'b0;
         end else if (mem_addr != cur.a || mem_wdata != cur.d || mem_wstrb != cur.s) begin
            cur.u = 1'b1;
         end
         cur_cyc++;
         cur.a = mem_addr; cur.d = mem_wdata; cur.s = mem_wstrb; cur.cyc = cur_cyc;
      end else if (pmv) begin
         bus_q.push_back(cur);
      end
      pmv = mem_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] a, input logic [31:0] d);
      send(8'h57);
      for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
   endtask

   task automatic send_r(input logic [31:0] a);
      send(8'h52);
      for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
   endtask

   task automatic wait_done(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (!busy && !mem_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick(2);
      tests++;
      if ({mem_valid, tx_valid, rx_drop, busy, mem_wstrb, mem_addr, mem_wdata, tx_data, mem_instr} !== '0) begin
         fails++;
         $display("FAIL reset_state got v=%b tv=%b d=%b b=%b s=%h a=%h w=%h t=%h i=%b exp all 0",
                  mem_valid, tx_valid, rx_drop, busy, mem_wstrb, mem_addr, mem_wdata, tx_data, mem_instr);
      end
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_write;
      bit ok; bus_rec_t r; logic [7:0] e, g;
      resp_en = 1'b1; ack_lat = 1;
      exp_q.push_back(8'h4B);
      send_w(32'h0000_0100, 32'hDEAD_BEEF);
      wait_done(200, ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL wr_done timeout"); end
      tests++; if (bus_q.size() != 1) begin fails++; $display("FAIL wr_bus_cnt got %0d exp 1", bus_q.size()); end
      if (bus_q.size() > 0) begin
         r = bus_q.pop_front();
         tests++;
         if (r.a !== 32'h100 || r.d !== 32'hDEADBEEF || r.s !== 4'hF || r.cyc != 2 || r.u) begin
            fails++;
            $display("FAIL wr_bus got a=%h d=%h s=%h cyc=%0d u=%b exp a=100 d=deadbeef s=f cyc=2 u=0",
                     r.a, r.d, r.s, r.cyc, r.u);
         end
      end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL wr_tx_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL wr_tx got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); bus_q.delete();
   endtask

   task automatic test_read_rand;
      bit ok; bus_rec_t r; logic [7:0] e, g;
      resp_en = 1'b1; ack_lat = 2; rdata_val = 32'h1234_5678; rand_rdy = 1'b1; hold_err = 0;
      exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
      send_r(32'h0000_0100);
      wait_done(400, ok);
      rand_rdy = 1'b0;
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rd_done timeout"); end
      tests++; if (bus_q.size() != 1) begin fails++; $display("FAIL rd_bus_cnt got %0d exp 1", bus_q.size()); end
      if (bus_q.size() > 0) begin
         r = bus_q.pop_front();
         tests++;
         if (r.a !== 32'h100 || r.s !== 4'h0 || r.cyc != 3 || r.u) begin
            fails++;
            $display("FAIL rd_bus got a=%h s=%h cyc=%0d u=%b exp a=100 s=0 cyc=3 u=0", r.a, r.s, r.cyc, r.u);
         end
      end
      tests++; if (hold_err != 0) begin fails++; $display("FAIL rd_tx_hold got %0d violations exp 0", hold_err); end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rd_tx_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL rd_tx got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); bus_q.delete();
   endtask

   task automatic test_bus_timeout;
      bit ok; bus_rec_t r; logic [7:0] e, g;
      resp_en = 1'b0;
      exp_q.push_back(8'h45);
      send_r(32'h0300_0000);
      wait_done(300, ok);
      tests++; if (ok !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL to_done ok=%b busy=%b exp 1,0", ok, busy); end
      tests++; if (bus_q.size() != 1) begin fails++; $display("FAIL to_bus_cnt got %0d exp 1", bus_q.size()); end
      if (bus_q.size() > 0) begin
         r = bus_q.pop_front();
         tests++;
         if (r.a !== 32'h0300_0000 || r.cyc != BT) begin
            fails++;
            $display("FAIL to_bus got a=%h cyc=%0d exp a=03000000 cyc=%0d", r.a, r.cyc, BT);
         end
      end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL to_tx_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL to_tx got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); bus_q.delete();
   endtask

   task automatic test_noise_frame_timeout;
      bit ok; bus_rec_t r; logic [7:0] e, g;
      send(8'h00); tick(1); send(8'hFF); tick(1);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL noise_busy got %b exp 0", busy); end
      send(8'h57); send(8'h11); send(8'h22);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL partial_busy got %b exp 1", busy); end
      tick(FT + 20);
      tests++;
      if (busy !== 1'b0 || bus_q.size() != 0 || got_q.size() != 0) begin
         fails++;
         $display("FAIL frame_to got busy=%b bus=%0d tx=%0d exp 0,0,0", busy, bus_q.size(), got_q.size());
      end
      resp_en = 1'b1; ack_lat = 0; rdata_val = 32'hA5A5_0001;
      exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
      send_r(32'h0000_0203);
      wait_done(200, ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL nz_done timeout"); end
      tests++; if (bus_q.size() != 1) begin fails++; $display("FAIL nz_bus_cnt got %0d exp 1", bus_q.size()); end
      if (bus_q.size() > 0) begin
         r = bus_q.pop_front();
         tests++;
         if (r.a !== 32'h200 || r.s !== 4'h0 || r.cyc != 1) begin
            fails++;
            $display("FAIL nz_bus got a=%h s=%h cyc=%0d exp a=200 s=0 cyc=1", r.a, r.s, r.cyc);
         end
      end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL nz_tx_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL nz_tx got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); bus_q.delete();
   endtask

   task automatic test_rx_drop;
      bit ok; bus_rec_t r; logic [7:0] e, g;
      resp_en = 1'b1; ack_lat = 10; drops = 0;
      exp_q.push_back(8'h4B);
      send_w(32'h0000_0020, 32'h0000_55AA);
      send(8'h57); tick(1); send(8'h52); tick(1); send(8'h41);
      wait_done(200, ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL drop_done timeout"); end
      tests++; if (drops != 3) begin fails++; $display("FAIL drop_cnt got %0d exp 3", drops); end
      tests++; if (bus_q.size() != 1) begin fails++; $display("FAIL drop_bus_cnt got %0d exp 1", bus_q.size()); end
      if (bus_q.size() > 0) begin
         r = bus_q.pop_front();
         tests++;
         if (r.a !== 32'h20 || r.d !== 32'h55AA || r.s !== 4'hF || r.cyc != 11 || r.u) begin
            fails++;
            $display("FAIL drop_bus got a=%h d=%h s=%h cyc=%0d u=%b exp a=20 d=55aa s=f cyc=11 u=0",
                     r.a, r.d, r.s, r.cyc, r.u);
         end
      end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL drop_tx_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL drop_tx got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); bus_q.delete();
   endtask

   task automatic test_reset_mid_bus;
      bit ok; bus_rec_t r; logic [7:0] e, g;
      resp_en = 1'b0;
      send_r(32'h0000_0040);
      tests++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL rst_bus_start got %b exp 1", mem_valid); end
      tick(3);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tests++;
      if (mem_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_abort got v=%b busy=%b exp 0,0", mem_valid, busy);
      end
      tick(BT + 20);
      tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rst_no_tx got %0d bytes exp 0", got_q.size()); end
      got_q.delete(); bus_q.delete();
      resp_en = 1'b1; ack_lat = 0;
      exp_q.push_back(8'h4B);
      send_w(32'h0000_0080, 32'hCAFE_F00D);
      wait_done(200, ok);
      tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rst_wr_done timeout"); end
      tests++; if (bus_q.size() != 1) begin fails++; $display("FAIL rst_wr_bus_cnt got %0d exp 1", bus_q.size()); end
      if (bus_q.size() > 0) begin
         r = bus_q.pop_front();
         tests++;
         if (r.a !== 32'h80 || r.d !== 32'hCAFEF00D || r.s !== 4'hF || r.cyc != 1) begin
            fails++;
            $display("FAIL rst_wr_bus got a=%h d=%h s=%h cyc=%0d exp a=80 d=cafef00d s=f cyc=1",
                     r.a, r.d, r.s, r.cyc);
         end
      end
      tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_wr_tx_len got %0d exp %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         tests++; if (g !== e) begin fails++; $display("FAIL rst_wr_tx got %h exp %h", g, e); end
      end
      exp_q.delete(); got_q.delete(); bus_q.delete();
   endtask

   initial begin
      test_reset;
      test_write;
      test_read_rand;
      test_bus_timeout;
      test_noise_frame_timeout;
      test_rx_drop;
      test_reset_mid_bus;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired, simulation did not finish");
      $fatal(1);
   end

endmodule
